// File: rtl/prf_free_list_pkg.sv
// Shared types and helpers for the rename / retirement slice.
//   NUM_WAYS, NUM_PRF, NUM_REGS : default machine geometry
//   FL_DEPTH                    : free-list depth (physical minus architectural)
//   prn_t / arn_t               : physical / architectural register numbers
//   rob_entry_t                 : ROB payload seen at commit
//   popcount()                  : set-bit count of a way mask (up to 32 ways)
package prf_free_list_pkg;

    localparam int NUM_WAYS = 3;
    localparam int NUM_PRF  = 64;
    localparam int NUM_REGS = 32;
    localparam int FL_DEPTH = NUM_PRF - NUM_REGS;
    localparam int PRN_W    = $clog2(NUM_PRF);
    localparam int ARN_W    = $clog2(NUM_REGS);

    typedef logic [PRN_W-1:0] prn_t;
    typedef logic [ARN_W-1:0] arn_t;

    typedef struct packed {
        logic valid;
        logic wr_reg;
        arn_t arn;
        prn_t prn;
    } rob_entry_t;

    function automatic int unsigned popcount(input logic [31:0] mask);
        int unsigned cnt;
        cnt = 0;
        for (int i = 0; i < 32; i++) begin
            cnt = cnt + 32'(mask[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/prf_free_list_arch_map.sv
// Retirement (architectural) register map.
//   clock, reset     : rising-edge clock, asynchronous active-low reset
//   wr_en/arn/prn    : WAYS ordered write ports, way 0 oldest
//   old_prn          : mapping each way supersedes, with same-cycle bypass
//   arch_map_out     : registered map, REGS entries
module prf_free_list_arch_map #(
    parameter int WAYS = 3,
    parameter int PRF  = 64,
    parameter int REGS = 32
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic [WAYS-1:0]                     wr_en,
    input  logic [WAYS-1:0][$clog2(REGS)-1:0]   wr_arn,
    input  logic [WAYS-1:0][$clog2(PRF)-1:0]    wr_prn,
    output logic [WAYS-1:0][$clog2(PRF)-1:0]    old_prn,
    output logic [REGS-1:0][$clog2(PRF)-1:0]    arch_map_out
);

    localparam int PW = $clog2(PRF);

    logic [REGS-1:0][PW-1:0] map_q;

    // A later way writing the same ARN supersedes the earlier way's PRN, not
    // the stale registered one; scanning upward leaves the newest match.
    always_comb begin
        old_prn = '0;
        for (int j = 0; j < WAYS; j++) begin
            old_prn[j] = map_q[wr_arn[j]];
            for (int k = 0; k < j; k++) begin
                if (wr_en[k] && (wr_arn[k] == wr_arn[j])) begin
                    old_prn[j] = wr_prn[k];
                end
            end
        end
    end

    // Ways are written in order so the youngest same-ARN write lands last.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < REGS; i++) begin
                map_q[i] <= PW'(i);
            end
        end else begin
            for (int j = 0; j < WAYS; j++) begin
                if (wr_en[j]) begin
                    map_q[wr_arn[j]] <= wr_prn[j];
                end
            end
        end
    end

    assign arch_map_out = map_q;

endmodule

// File: rtl/prf_free_list.sv
// Physical-register free list with retirement map.
//   clock, reset      : rising-edge clock, asynchronous active-low reset
//   alloc_req         : per-way PRN request from dispatch (contiguous from way 0)
//   alloc_PRN         : combinational grant per way
//   num_free          : free entries at start of cycle
//   commit_valid/ARN/PRN : ROB register-writing commits, way 0 oldest
//   rollback          : ROB flush; refills the list, keeps this cycle's commits
//   arch_map_out      : registered architectural map for RAT rebuild
//   error             : sticky protocol-violation flag
module prf_free_list
    import prf_free_list_pkg::*;
#(
    parameter int WAYS = NUM_WAYS,
    parameter int PRF  = NUM_PRF,
    parameter int REGS = NUM_REGS
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic [WAYS-1:0]                     alloc_req,
    output logic [WAYS-1:0][$clog2(PRF)-1:0]    alloc_PRN,
    output logic [$clog2(PRF-REGS):0]           num_free,
    input  logic [WAYS-1:0]                     commit_valid,
    input  logic [WAYS-1:0][$clog2(REGS)-1:0]   commit_ARN,
    input  logic [WAYS-1:0][$clog2(PRF)-1:0]    commit_PRN,
    input  logic                                rollback,
    output logic [REGS-1:0][$clog2(PRF)-1:0]    arch_map_out,
    output logic                                error
);

    localparam int PW = $clog2(PRF);
    localparam int N  = PRF - REGS;
    localparam int IW = $clog2(N);
    localparam int CW = $clog2(N) + 1;

    // N need not be a power of two, so wrap with a compare-subtract.
    function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] ptr,
                                               input logic [CW-1:0] inc);
        logic [CW:0] sum;
        sum = (CW+1)'(ptr) + (CW+1)'(inc);
        if (sum >= (CW+1)'(N)) begin
            sum = sum - (CW+1)'(N);
        end
        return IW'(sum);
    endfunction

    logic [N-1:0][PW-1:0]     list_q;
    logic [IW-1:0]            head_q;
    logic [IW-1:0]            tail_q;
    logic [CW-1:0]            count_q;
    logic                     error_q;

    logic [CW-1:0]            n_alloc;
    logic [CW-1:0]            n_alloc_eff;
    logic                     alloc_ok;
    logic [WAYS-1:0]          commit_en;
    logic                     arn_zero_err;
    logic [WAYS-1:0][IW-1:0]  commit_slot;
    logic                     commit_mismatch;
    logic [CW-1:0]            n_free;
    logic [CW-1:0]            count_sum;
    logic [IW-1:0]            tail_next;
    logic [WAYS-1:0][PW-1:0]  old_prn;

    assign num_free = count_q;
    assign error    = error_q;

    always_comb begin
        alloc_PRN = '0;
        for (int i = 0; i < WAYS; i++) begin
            alloc_PRN[i] = list_q[wrap_add(head_q, CW'(i))];
        end
    end

    // An over-request allocates nothing rather than a partial group.
    assign n_alloc     = CW'(popcount(32'(alloc_req)));
    assign alloc_ok    = (n_alloc <= count_q);
    assign n_alloc_eff = alloc_ok ? n_alloc : '0;

    // x0 is never renamed, so a commit to it is dropped and does not consume
    // a list slot; the remaining ways pack into consecutive slots from tail.
    always_comb begin
        commit_en       = '0;
        commit_slot     = '0;
        commit_mismatch = 1'b0;
        n_free          = '0;
        for (int j = 0; j < WAYS; j++) begin
            commit_en[j]   = commit_valid[j] && (commit_ARN[j] != '0);
            commit_slot[j] = wrap_add(tail_q, n_free);
            if (commit_en[j]) begin
                if (commit_PRN[j] != list_q[commit_slot[j]]) begin
                    commit_mismatch = 1'b1;
                end
                n_free = n_free + CW'(1);
            end
        end
    end

    assign arn_zero_err = |(commit_valid & ~commit_en);
    assign count_sum    = count_q - n_alloc_eff + n_free;
    assign tail_next    = wrap_add(tail_q, n_free);

    prf_free_list_arch_map #(
        .WAYS (WAYS),
        .PRF  (PRF),
        .REGS (REGS)
    ) u_arch_map (
        .clock        (clock),
        .reset        (reset),
        .wr_en        (commit_en),
        .wr_arn       (commit_ARN),
        .wr_prn       (commit_PRN),
        .old_prn      (old_prn),
        .arch_map_out (arch_map_out)
    );

    // On rollback every in-flight PRN still sits in [tail, head), so moving
    // head back to the new tail returns them all to the free pool.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < N; k++) begin
                list_q[k] <= PW'(REGS + k);
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= CW'(N);
            error_q <= 1'b0;
        end else begin
            for (int j = 0; j < WAYS; j++) begin
                if (commit_en[j]) begin
                    list_q[commit_slot[j]] <= old_prn[j];
                end
            end
            tail_q <= tail_next;
            if (rollback) begin
                head_q  <= tail_next;
                count_q <= CW'(N);
            end else begin
                head_q  <= wrap_add(head_q, n_alloc_eff);
                count_q <= count_sum;
            end
            if (!alloc_ok || commit_mismatch || arn_zero_err ||
                (!rollback && (count_sum > CW'(N)))) begin
                error_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_prf_free_list.sv
// Directed bench for prf_free_list (WAYS=3, PRF=64, REGS=32).
module tb_prf_free_list;

    localparam int WAYS = 3;
    localparam int PRF  = 64;
    localparam int REGS = 32;
    localparam int PW   = 6;
    localparam int AW   = 5;
    localparam int CW   = 6;

    logic                          clock = 1'b0;
    logic                          reset;
    logic [WAYS-1:0]               alloc_req;
    logic [WAYS-1:0][PW-1:0]       alloc_PRN;
    logic [CW-1:0]                 num_free;
    logic [WAYS-1:0]               commit_valid;
    logic [WAYS-1:0][AW-1:0]       commit_ARN;
    logic [WAYS-1:0][PW-1:0]       commit_PRN;
    logic                          rollback;
    logic [REGS-1:0][PW-1:0]       arch_map_out;
    logic                          error;

    int checks = 0;
    int errors = 0;
    int seq [30];

    always #5 clock = ~clock;

    prf_free_list #(
        .WAYS (WAYS),
        .PRF  (PRF),
        .REGS (REGS)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .alloc_req    (alloc_req),
        .alloc_PRN    (alloc_PRN),
        .num_free     (num_free),
        .commit_valid (commit_valid),
        .commit_ARN   (commit_ARN),
        .commit_PRN   (commit_PRN),
        .rollback     (rollback),
        .arch_map_out (arch_map_out),
        .error        (error)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_alloc(input string tag, input int a0, input int a1, input int a2);
        chk({tag, "_prn0"}, 32'(alloc_PRN[0]), a0);
        chk({tag, "_prn1"}, 32'(alloc_PRN[1]), a1);
        chk({tag, "_prn2"}, 32'(alloc_PRN[2]), a2);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        alloc_req    = '0;
        commit_valid = '0;
        commit_ARN   = '0;
        commit_PRN   = '0;
        rollback     = 1'b0;
    endtask

    task automatic commit3(input logic [2:0] v, input int a0, input int p0,
                           input int a1, input int p1, input int a2, input int p2);
        commit_valid  = v;
        commit_ARN[0] = AW'(a0);
        commit_PRN[0] = PW'(p0);
        commit_ARN[1] = AW'(a1);
        commit_PRN[1] = PW'(p1);
        commit_ARN[2] = AW'(a2);
        commit_PRN[2] = PW'(p2);
    endtask

    initial begin
        idle();
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
        #1;
        chk("rst_num_free", 32'(num_free), 32);
        chk_alloc("rst_alloc", 32, 33, 34);
        chk("rst_map5", 32'(arch_map_out[5]), 5);
        chk("rst_map31", 32'(arch_map_out[31]), 31);
        chk("rst_error", 32'(error), 0);

        // allocate three, then commit them to ARNs 1..3
        alloc_req = 3'b111;
        #1 chk_alloc("a3_grant", 32, 33, 34);
        tick();
        idle();
        #1;
        chk("a3_num_free", 32'(num_free), 29);
        chk_alloc("a3_next", 35, 36, 37);
        commit3(3'b111, 1, 32, 2, 33, 3, 34);
        tick();
        idle();
        #1;
        chk("c3_map1", 32'(arch_map_out[1]), 32);
        chk("c3_map2", 32'(arch_map_out[2]), 33);
        chk("c3_map3", 32'(arch_map_out[3]), 34);
        chk("c3_num_free", 32'(num_free), 32);
        chk("c3_error", 32'(error), 0);

        // same ARN twice in one commit group
        alloc_req = 3'b011;
        #1;
        chk("same_grant0", 32'(alloc_PRN[0]), 35);
        chk("same_grant1", 32'(alloc_PRN[1]), 36);
        tick();
        idle();
        commit3(3'b011, 7, 35, 7, 36, 0, 0);
        tick();
        idle();
        #1;
        chk("same_map7", 32'(arch_map_out[7]), 36);
        chk("same_num_free", 32'(num_free), 32);
        chk("same_error", 32'(error), 0);

        // rollback with six in flight; this cycle's alloc must be discarded
        alloc_req = 3'b111;
        tick();
        tick();
        idle();
        #1;
        chk("rb_pre_num_free", 32'(num_free), 26);
        chk_alloc("rb_pre_alloc", 43, 44, 45);
        commit3(3'b001, 4, 37, 0, 0, 0, 0);
        rollback  = 1'b1;
        alloc_req = 3'b111;
        tick();
        idle();
        #1;
        chk("rb_num_free", 32'(num_free), 32);
        chk_alloc("rb_alloc", 38, 39, 40);
        chk("rb_map4", 32'(arch_map_out[4]), 37);
        chk("rb_error", 32'(error), 0);

        // drain to two free entries, crossing the head wrap
        alloc_req = 3'b111;
        repeat (8) tick();
        #1 chk_alloc("wrap_g8", 62, 63, 1);
        tick();
        #1 chk_alloc("wrap_g9", 2, 3, 7);
        tick();
        idle();
        #1;
        chk("low_num_free", 32'(num_free), 2);
        chk_alloc("low_alloc", 35, 4, 38);
        alloc_req = 3'b111;
        tick();
        idle();
        #1;
        chk("over_error", 32'(error), 1);
        chk("over_num_free", 32'(num_free), 2);
        chk_alloc("over_alloc", 35, 4, 38);

        // commit all 30 in flight in allocation order, crossing the tail wrap
        for (int k = 0; k < 26; k++) seq[k] = 38 + k;
        seq[26] = 1;
        seq[27] = 2;
        seq[28] = 3;
        seq[29] = 7;
        for (int g = 0; g < 10; g++) begin
            commit3(3'b111,
                    10 + (3*g) % 20,     seq[3*g],
                    10 + (3*g + 1) % 20, seq[3*g + 1],
                    10 + (3*g + 2) % 20, seq[3*g + 2]);
            tick();
        end
        idle();
        #1;
        chk("drain_num_free", 32'(num_free), 32);
        chk("drain_map10", 32'(arch_map_out[10]), 58);
        chk("drain_map19", 32'(arch_map_out[19]), 7);
        chk("drain_map20", 32'(arch_map_out[20]), 48);
        chk("drain_map25", 32'(arch_map_out[25]), 53);
        chk_alloc("drain_alloc", 35, 4, 10);
        chk("drain_error_sticky", 32'(error), 1);

        // simultaneous alloc 3 / commit 2 at ten free
        alloc_req = 3'b111;
        repeat (7) tick();
        alloc_req = 3'b001;
        tick();
        idle();
        #1;
        chk("sim_pre_num_free", 32'(num_free), 10);
        alloc_req = 3'b111;
        commit3(3'b011, 5, 35, 6, 4, 0, 0);
        #1 chk_alloc("sim_grant", 38, 39, 40);
        tick();
        idle();
        #1;
        chk("sim_num_free", 32'(num_free), 9);
        chk_alloc("sim_next", 41, 42, 43);
        chk("sim_map5", 32'(arch_map_out[5]), 35);
        chk("sim_map6", 32'(arch_map_out[6]), 4);

        // asynchronous reset mid-cycle
        #1 reset = 1'b0;
        #1;
        chk("areset_num_free", 32'(num_free), 32);
        chk("areset_error", 32'(error), 0);
        chk_alloc("areset_alloc", 32, 33, 34);
        chk("areset_map10", 32'(arch_map_out[10]), 10);
        chk("areset_map5", 32'(arch_map_out[5]), 5);
        tick();
        reset = 1'b1;
        #1;

        // commit to x0 is ignored and flagged
        commit3(3'b001, 0, 32, 0, 0, 0, 0);
        tick();
        idle();
        #1;
        chk("x0_error", 32'(error), 1);
        chk("x0_num_free", 32'(num_free), 32);
        chk("x0_map0", 32'(arch_map_out[0]), 0);
        chk_alloc("x0_alloc", 32, 33, 34);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
